// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the MEM stage and the dmem responder.
interface dmem_responder_if;
    logic        mem_req;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        ack;
    logic [31:0] rdata;
    logic        error;

    modport master (
        output mem_req, mem_write, mem_size, addr, wdata,
        input  stall, ack, rdata, error
    );

    modport slave (
        input  mem_req, mem_write, mem_size, addr, wdata,
        output stall, ack, rdata, error
    );
endinterface

// File: rtl/dmem_responder.sv
// Wait-state dmem responder: latches one request, stalls LATENCY cycles, then commits
// a byte-lane store or returns a right-justified load in a single ack cycle.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
    parameter int unsigned LATENCY    = 2
) (
    input logic             clk,
    input logic             reset_x,
    dmem_responder_if.slave bus
);
    localparam logic [1:0]  IDLE    = 2'd0;
    localparam logic [1:0]  BUSY    = 2'd1;
    localparam logic [1:0]  RESP    = 2'd2;
    localparam int unsigned WORDS   = 1 << DEPTH_LOG2;
    localparam logic [31:0] HI_MASK = ~((32'd4 << DEPTH_LOG2) - 32'd1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_write_q;
    logic [1:0]  req_size_q;
    logic [31:0] req_addr_q, req_wdata_q;
    logic        ack_q, error_q;
    logic [31:0] rdata_q;
    logic [31:0] mem [WORDS];

    logic                  cur_write;
    logic [1:0]            cur_size;
    logic [31:0]           cur_addr, cur_wdata;
    logic                  accept, commit, err;
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            lane;
    logic [3:0]            be;
    logic [31:0]           lane_data, shifted, load_data;

    // With LATENCY=0 the commit happens on the accept edge, so fields come straight off the bus.
    always_comb begin
        if (state_q == IDLE) begin
            cur_write = bus.mem_write;
            cur_size  = bus.mem_size;
            cur_addr  = bus.addr;
            cur_wdata = bus.wdata;
        end else begin
            cur_write = req_write_q;
            cur_size  = req_size_q;
            cur_addr  = req_addr_q;
            cur_wdata = req_wdata_q;
        end
    end

    assign accept = (state_q == IDLE) && bus.mem_req;
    assign commit = (accept && (LATENCY == 0)) || ((state_q == BUSY) && (cnt_q == 4'd1));
    assign idx    = cur_addr[DEPTH_LOG2+1:2];
    assign lane   = cur_addr[1:0];

    always_comb begin
        err = 1'b0;
        case (cur_size)
            2'b00:   err = 1'b0;
            2'b01:   err = cur_addr[0];
            2'b10:   err = (cur_addr[1:0] != 2'b00);
            default: err = 1'b1;
        endcase
        if (((cur_addr ^ BASE_ADDR) & HI_MASK) != 32'd0) err = 1'b1;
    end

    always_comb begin
        shifted = mem[idx] >> {lane, 3'b000};
        case (cur_size)
            2'b00: begin
                be        = 4'b0001 << lane;
                lane_data = {4{cur_wdata[7:0]}};
                load_data = {24'd0, shifted[7:0]};
            end
            2'b01: begin
                be        = 4'b0011 << lane;
                lane_data = {2{cur_wdata[15:0]}};
                load_data = {16'd0, shifted[15:0]};
            end
            default: begin
                be        = 4'b1111;
                lane_data = cur_wdata;
                load_data = shifted;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_req) begin
                    cnt_d   = 4'(LATENCY);
                    state_d = (LATENCY == 0) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_write_q <= 1'b0;
            req_size_q  <= 2'b00;
            req_addr_q  <= 32'd0;
            req_wdata_q <= 32'd0;
            ack_q       <= 1'b0;
            error_q     <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_write_q <= bus.mem_write;
                req_size_q  <= bus.mem_size;
                req_addr_q  <= bus.addr;
                req_wdata_q <= bus.wdata;
            end
            ack_q   <= commit;
            error_q <= commit && err;
            rdata_q <= (commit && !err && !cur_write) ? load_data : 32'd0;
        end
    end

    // Array is not reset; commit is gated by state, which reset forces to IDLE.
    always_ff @(posedge clk) begin
        if (commit && !err && cur_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    assign bus.stall = (state_q == IDLE) ? bus.mem_req : (state_q == BUSY);
    assign bus.ack   = ack_q;
    assign bus.error = error_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 and LATENCY=0 instances on a shared clock/reset.
module tb_dmem_responder;
    logic clk;
    logic reset_x;
    int   n_checks;
    int   n_errors;

    dmem_responder_if b2 ();
    dmem_responder_if b0 ();

    dmem_responder #(.LATENCY(2)) dut2 (.clk(clk), .reset_x(reset_x), .bus(b2));
    dmem_responder #(.LATENCY(0)) dut0 (.clk(clk), .reset_x(reset_x), .bus(b0));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Entered at posedge+1; returns at posedge+1 of the cycle after the ack.
    task automatic access2(input string tag, input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int lat,
                           output int stalls);
        b2.mem_req = 1'b1; b2.mem_write = wr; b2.mem_size = sz; b2.addr = a; b2.wdata = wd;
        lat = 0; stalls = 0;
        #1;
        while (!b2.ack && lat < 12) begin
            if (b2.stall) stalls++;
            @(posedge clk); #2;
            lat++;
        end
        check({tag, "_ack"}, 32'(b2.ack), 32'd1);
        check({tag, "_stall_in_ack"}, 32'(b2.stall), 32'd0);
        rd = b2.rdata; er = b2.error;
        b2.mem_req = 1'b0;
        @(posedge clk); #1;
        check({tag, "_ack_drop"}, {31'd0, b2.ack}, 32'd0);
    endtask

    task automatic access0(input string tag, input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int lat);
        b0.mem_req = 1'b1; b0.mem_write = wr; b0.mem_size = sz; b0.addr = a; b0.wdata = wd;
        lat = 0;
        #1;
        while (!b0.ack && lat < 12) begin
            @(posedge clk); #2;
            lat++;
        end
        check({tag, "_ack"}, 32'(b0.ack), 32'd1);
        rd = b0.rdata; er = b0.error;
        b0.mem_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, stalls, ack_seen;
        logic [6:0]  ack_hist;

        n_checks = 0; n_errors = 0;
        reset_x = 1'b0;
        b2.mem_req = 1'b0; b2.mem_write = 1'b0; b2.mem_size = 2'b00; b2.addr = 32'd0;
        b2.wdata = 32'd0;
        b0.mem_req = 1'b0; b0.mem_write = 1'b0; b0.mem_size = 2'b00; b0.addr = 32'd0;
        b0.wdata = 32'd0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_ack", {31'd0, b2.ack}, 32'd0);
        check("rst_error", {31'd0, b2.error}, 32'd0);
        check("rst_rdata", b2.rdata, 32'd0);
        check("rst_stall", {31'd0, b2.stall}, 32'd0);
        reset_x = 1'b1;
        @(posedge clk); #1;

        access2("st_word", 1'b1, 2'b10, 32'h0001_0008, 32'hDEAD_BEEF, rd, er, lat, stalls);
        check("st_word_lat", 32'(lat), 32'd3);
        check("st_word_stalls", 32'(stalls), 32'd3);
        check("st_word_err", {31'd0, er}, 32'd0);
        access2("ld_word", 1'b0, 2'b10, 32'h0001_0008, 32'd0, rd, er, lat, stalls);
        check("ld_word_data", rd, 32'hDEAD_BEEF);
        check("ld_word_lat", 32'(lat), 32'd3);

        access2("st_base", 1'b1, 2'b10, 32'h0001_0008, 32'h1122_3344, rd, er, lat, stalls);
        access2("st_byte", 1'b1, 2'b00, 32'h0001_000A, 32'h0000_00A5, rd, er, lat, stalls);
        check("st_byte_err", {31'd0, er}, 32'd0);
        access2("ld_merged", 1'b0, 2'b10, 32'h0001_0008, 32'd0, rd, er, lat, stalls);
        check("ld_merged_data", rd, 32'h11A5_3344);
        access2("ld_byte", 1'b0, 2'b00, 32'h0001_000A, 32'd0, rd, er, lat, stalls);
        check("ld_byte_data", rd, 32'h0000_00A5);

        access2("ld_half_mis", 1'b0, 2'b01, 32'h0001_0001, 32'd0, rd, er, lat, stalls);
        check("ld_half_mis_err", {31'd0, er}, 32'd1);
        check("ld_half_mis_data", rd, 32'd0);

        access2("st_w0", 1'b1, 2'b10, 32'h0001_0000, 32'h0BAD_F00D, rd, er, lat, stalls);
        access2("st_oor", 1'b1, 2'b10, 32'h0002_0000, 32'hFFFF_FFFF, rd, er, lat, stalls);
        check("st_oor_err", {31'd0, er}, 32'd1);
        access2("ld_w0", 1'b0, 2'b10, 32'h0001_0000, 32'd0, rd, er, lat, stalls);
        check("ld_w0_data", rd, 32'h0BAD_F00D);
        check("ld_w0_err", {31'd0, er}, 32'd0);

        access2("st_word_mis", 1'b1, 2'b10, 32'h0001_0006, 32'h5555_5555, rd, er, lat, stalls);
        check("st_word_mis_err", {31'd0, er}, 32'd1);

        access2("st_zero", 1'b1, 2'b10, 32'h0001_000C, 32'd0, rd, er, lat, stalls);
        access2("st_half", 1'b1, 2'b01, 32'h0001_000E, 32'h1234_BEEF, rd, er, lat, stalls);
        access2("ld_half_w", 1'b0, 2'b10, 32'h0001_000C, 32'd0, rd, er, lat, stalls);
        check("ld_half_w_data", rd, 32'hBEEF_0000);
        access2("ld_half", 1'b0, 2'b01, 32'h0001_000E, 32'd0, rd, er, lat, stalls);
        check("ld_half_data", rd, 32'h0000_BEEF);

        access2("ld_ill", 1'b0, 2'b11, 32'h0001_0008, 32'd0, rd, er, lat, stalls);
        check("ld_ill_err", {31'd0, er}, 32'd1);
        check("ld_ill_data", rd, 32'd0);
        check("ld_ill_idle_stall", {31'd0, b2.stall}, 32'd0);
        access2("ld_after_ill", 1'b0, 2'b10, 32'h0001_0008, 32'd0, rd, er, lat, stalls);
        check("ld_after_ill_lat", 32'(lat), 32'd3);
        check("ld_after_ill_data", rd, 32'h11A5_3344);

        // Store aborted by reset while in BUSY.
        b2.mem_req = 1'b1; b2.mem_write = 1'b1; b2.mem_size = 2'b10;
        b2.addr = 32'h0001_0008; b2.wdata = 32'h9999_9999;
        @(posedge clk); #1;
        reset_x = 1'b0; b2.mem_req = 1'b0;
        #1;
        check("rst_busy_stall", {31'd0, b2.stall}, 32'd0);
        ack_seen = 0;
        for (int c = 0; c < 3; c++) begin
            if (b2.ack) ack_seen++;
            @(posedge clk); #1;
        end
        reset_x = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (b2.ack) ack_seen++;
            @(posedge clk); #1;
        end
        check("rst_busy_no_ack", 32'(ack_seen), 32'd0);
        access2("ld_after_rst", 1'b0, 2'b10, 32'h0001_0008, 32'd0, rd, er, lat, stalls);
        check("ld_after_rst_data", rd, 32'h11A5_3344);

        access0("l0_st", 1'b1, 2'b10, 32'h0001_0010, 32'hCAFE_F00D, rd, er, lat);
        check("l0_st_lat", 32'(lat), 32'd1);
        check("l0_st_err", {31'd0, er}, 32'd0);

        // Continuous request: acks in cycles 1, 3, 5.
        b0.mem_req = 1'b1; b0.mem_write = 1'b0; b0.mem_size = 2'b10; b0.addr = 32'h0001_0010;
        ack_hist = 7'd0;
        for (int c = 0; c < 7; c++) begin
            #1;
            ack_hist[c] = b0.ack;
            if (b0.ack) check("l0_b2b_data", b0.rdata, 32'hCAFE_F00D);
            if (c == 5) b0.mem_req = 1'b0;
            @(posedge clk); #1;
        end
        check("l0_b2b_acks", {25'd0, ack_hist}, 32'h0000_002A);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
